// File: rtl/aibcr3_dll_lock_pkg.sv
// ---------------------------------------------------------------------------
// aibcr3_dll_lock_pkg
// Shared types and defaults for the DLL lock qualifier slice.
//   lock_st_t   : per-channel qualifier FSM state
//   DLY_DEFAULT : typical stable-lock interval programmed on rb_lock_dly
// Optional feature macro used across the slice: AIBCR3_LOCK_LOSS_CNT_EN
// ---------------------------------------------------------------------------
package aibcr3_dll_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lock_st_t;

    localparam int DLY_DEFAULT         = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/aibcr3_dll_lock_qual_if.sv
// ---------------------------------------------------------------------------
// aibcr3_dll_lock_qual_if
// Bundles the lock-qualifier control/status signals.
//   dll_lock_mux [NCH]   raw async lock per channel        (master -> slave)
//   rb_cont_cal          continuous-calibration mode       (master -> slave)
//   rb_lock_dly [CNT_W]  stable-lock interval              (master -> slave)
//   clr_lost [NCH]       clear sticky lock_lost            (master -> slave)
//   dll_lock_reg [NCH]   synchronised, masked lock         (slave -> master)
//   dcc_done [NCH]       qualified lock                    (slave -> master)
//   lock_lost [NCH]      sticky lock-loss flag             (slave -> master)
//   loss_cnt             NCH*LOSS_CNT_W saturating counts  (slave -> master)
//                        present only with AIBCR3_LOCK_LOSS_CNT_EN
// ---------------------------------------------------------------------------
interface aibcr3_dll_lock_qual_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 4
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
   ,parameter int LOSS_CNT_W = 4
`endif
);
    logic [NCH-1:0]   dll_lock_mux;
    logic             rb_cont_cal;
    logic [CNT_W-1:0] rb_lock_dly;
    logic [NCH-1:0]   clr_lost;
    logic [NCH-1:0]   dll_lock_reg;
    logic [NCH-1:0]   dcc_done;
    logic [NCH-1:0]   lock_lost;
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
    logic [NCH*LOSS_CNT_W-1:0] loss_cnt;

    modport master (output dll_lock_mux, rb_cont_cal, rb_lock_dly, clr_lost,
                    input  dll_lock_reg, dcc_done, lock_lost, loss_cnt);
    modport slave  (input  dll_lock_mux, rb_cont_cal, rb_lock_dly, clr_lost,
                    output dll_lock_reg, dcc_done, lock_lost, loss_cnt);
`else
    modport master (output dll_lock_mux, rb_cont_cal, rb_lock_dly, clr_lost,
                    input  dll_lock_reg, dcc_done, lock_lost);
    modport slave  (input  dll_lock_mux, rb_cont_cal, rb_lock_dly, clr_lost,
                    output dll_lock_reg, dcc_done, lock_lost);
`endif
endinterface

// File: rtl/aibcr3_dll_lock_chan.sv
// ---------------------------------------------------------------------------
// aibcr3_dll_lock_chan
// One DLL channel: synchroniser on the raw lock, qualifier FSM with a
// stable-lock delay counter, sticky loss flag and (optionally) a saturating
// loss counter.
//   clk_dcd, RST  clock / synchronous active-high reset
//   lock_mux      raw async lock
//   lock_dly      programmed stable-lock interval (0 behaves as 1)
//   clr_lost      clear sticky flag (and loss counter)
//   lock_s        last synchroniser stage
//   dcc_done      qualified lock (registered)
//   lock_lost     sticky: lock dropped while qualified
//   loss_cnt      saturating loss count (only with AIBCR3_LOCK_LOSS_CNT_EN)
// ---------------------------------------------------------------------------
module aibcr3_dll_lock_chan
    import aibcr3_dll_lock_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = 4
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
   ,parameter int LOSS_CNT_W  = 4
`endif
) (
    input  logic             clk_dcd,
    input  logic             RST,
    input  logic             lock_mux,
    input  logic [CNT_W-1:0] lock_dly,
    input  logic             clr_lost,
    output logic             lock_s,
    output logic             dcc_done,
    output logic             lock_lost
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
   ,output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    lock_st_t               st_q, st_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [CNT_W-1:0]       dly_q, dly_nxt;
    logic [CNT_W-1:0]       dly_in;
    logic                   done_q;
    logic                   lost_q;
    logic                   lost_set;

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign dly_in    = (lock_dly == '0) ? CNT_W'(1) : lock_dly;
    assign dcc_done  = done_q;
    assign lock_lost = lost_q;

    // The IDLE cycle that first sees lock_s counts as stable cycle 1, so WAIT
    // starts at cnt=1 and a one-cycle interval goes straight to DONE. This
    // gives done exactly dly_q edges after lock_s rises.
    always_comb begin
        st_nxt   = st_q;
        cnt_nxt  = cnt_q;
        dly_nxt  = dly_q;
        lost_set = 1'b0;
        case (st_q)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    dly_nxt = dly_in;
                    if (dly_in == CNT_W'(1)) begin
                        st_nxt = ST_DONE;
                    end else begin
                        st_nxt  = ST_WAIT;
                        cnt_nxt = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (!lock_s) begin
                    st_nxt  = ST_IDLE;
                    cnt_nxt = '0;
                end else if (cnt_q == dly_q - CNT_W'(1)) begin
                    st_nxt  = ST_DONE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!lock_s) begin
                    st_nxt   = ST_IDLE;
                    lost_set = 1'b1;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_dcd) begin
        if (RST) begin
            sync_q <= '0;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            dly_q  <= '0;
            done_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_mux};
            st_q   <= st_nxt;
            cnt_q  <= cnt_nxt;
            dly_q  <= dly_nxt;
            done_q <= (st_nxt == ST_DONE);
            // a new loss outranks a simultaneous clear
            if (lost_set)
                lost_q <= 1'b1;
            else if (clr_lost)
                lost_q <= 1'b0;
        end
    end

`ifdef AIBCR3_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    assign loss_cnt = loss_q;

    always_ff @(posedge clk_dcd) begin
        if (RST)
            loss_q <= '0;
        else if (clr_lost)
            loss_q <= lost_set ? LOSS_CNT_W'(1) : '0;
        else if (lost_set && (loss_q != '1))
            loss_q <= loss_q + LOSS_CNT_W'(1);
    end
`endif

endmodule

// File: rtl/aibcr3_dll_lock_qual.sv
// ---------------------------------------------------------------------------
// aibcr3_dll_lock_qual
// Multi-channel DLL lock qualifier for the DCC/DLL calibration path.
// Instantiates one aibcr3_dll_lock_chan per channel and masks the
// synchronised lock with continuous-calibration mode.
//   clk_dcd  clock, all state on rising edge
//   RST      synchronous active-high reset
//   bus      aibcr3_dll_lock_qual_if.slave (lock inputs, controls, status)
// Optional feature: AIBCR3_LOCK_LOSS_CNT_EN adds per-channel loss_cnt.
// ---------------------------------------------------------------------------
module aibcr3_dll_lock_qual
    import aibcr3_dll_lock_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = 4
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
   ,parameter int LOSS_CNT_W  = 4
`endif
) (
    input  logic                         clk_dcd,
    input  logic                         RST,
    aibcr3_dll_lock_qual_if.slave        bus
);

    logic [NCH-1:0] lock_s;
    logic [NCH-1:0] done;
    logic [NCH-1:0] lost;
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
    logic [NCH*LOSS_CNT_W-1:0] lcnt;
    assign bus.loss_cnt = lcnt;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        aibcr3_dll_lock_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
           ,.LOSS_CNT_W  (LOSS_CNT_W)
`endif
        ) u_chan (
            .clk_dcd  (clk_dcd),
            .RST      (RST),
            .lock_mux (bus.dll_lock_mux[i]),
            .lock_dly (bus.rb_lock_dly),
            .clr_lost (bus.clr_lost[i]),
            .lock_s   (lock_s[i]),
            .dcc_done (done[i]),
            .lock_lost(lost[i])
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
           ,.loss_cnt (lcnt[i*LOSS_CNT_W +: LOSS_CNT_W])
`endif
        );
    end

    // masking is combinational so leaving continuous-cal is visible at once
    assign bus.dll_lock_reg = bus.rb_cont_cal ? '0 : lock_s;
    assign bus.dcc_done     = done;
    assign bus.lock_lost    = lost;

endmodule

// File: tb/tb_aibcr3_dll_lock_qual.sv
// ---------------------------------------------------------------------------
// tb_aibcr3_dll_lock_qual
// Directed bench for aibcr3_dll_lock_qual with a run-length reference model.
// Honours AIBCR3_LOCK_LOSS_CNT_EN for the loss counter checks.
// ---------------------------------------------------------------------------
module tb_aibcr3_dll_lock_qual;
    localparam int NCH = 4;
    localparam int CNT_W = 4;
    localparam int LW = 4;

    logic clk_dcd = 1'b0;
    logic RST;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk_dcd = ~clk_dcd;

`ifdef AIBCR3_LOCK_LOSS_CNT_EN
    aibcr3_dll_lock_qual_if #(.NCH(NCH), .CNT_W(CNT_W), .LOSS_CNT_W(LW)) bus ();
    aibcr3_dll_lock_qual #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(CNT_W), .LOSS_CNT_W(LW))
        dut (.clk_dcd(clk_dcd), .RST(RST), .bus(bus));
`else
    aibcr3_dll_lock_qual_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();
    aibcr3_dll_lock_qual #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(CNT_W))
        dut (.clk_dcd(clk_dcd), .RST(RST), .bus(bus));
`endif

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: lock_s is the mux delayed two edges; done holds once
    // lock_s has been high for the latched interval of consecutive edges.
    logic [NCH-1:0] m_s1, m_s2;
    int m_run  [NCH];
    int m_dly  [NCH];
    bit m_done [NCH];
    bit m_lost [NCH];
    int m_cnt  [NCH];

    always @(posedge clk_dcd) begin
        bit drop;
        if (RST) begin
            m_s1 = '0;
            m_s2 = '0;
            for (int i = 0; i < NCH; i++) begin
                m_run[i] = 0; m_dly[i] = 1; m_done[i] = 0; m_lost[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                drop = 0;
                if (m_s2[i]) begin
                    m_run[i]++;
                    if (m_run[i] == 1)
                        m_dly[i] = (bus.rb_lock_dly == 0) ? 1 : int'(bus.rb_lock_dly);
                    if (m_run[i] >= m_dly[i]) m_done[i] = 1;
                end else begin
                    drop = m_done[i];
                    m_run[i] = 0;
                    m_done[i] = 0;
                end
                if (drop) m_lost[i] = 1;
                else if (bus.clr_lost[i]) m_lost[i] = 0;
                if (bus.clr_lost[i]) m_cnt[i] = drop ? 1 : 0;
                else if (drop && m_cnt[i] < (1 << LW) - 1) m_cnt[i]++;
            end
            m_s2 = m_s1;
            m_s1 = bus.dll_lock_mux;
        end
    end

    // Compare every cycle, mid-period (inputs change 2 units after posedge).
    always @(negedge clk_dcd) begin
        logic [NCH-1:0] e_done, e_lost, e_reg;
        for (int i = 0; i < NCH; i++) begin
            e_done[i] = m_done[i];
            e_lost[i] = m_lost[i];
            e_reg[i]  = bus.rb_cont_cal ? 1'b0 : m_s2[i];
        end
        chk("cyc_dcc_done", 32'(bus.dcc_done), 32'(e_done));
        chk("cyc_lock_lost", 32'(bus.lock_lost), 32'(e_lost));
        chk("cyc_dll_lock_reg", 32'(bus.dll_lock_reg), 32'(e_reg));
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
        for (int i = 0; i < NCH; i++)
            chk("cyc_loss_cnt", 32'(bus.loss_cnt[i*LW +: LW]), 32'(m_cnt[i]));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_dcd);
        #2;
    endtask

    initial begin
        RST = 1'b1;
        bus.dll_lock_mux = '1;
        bus.rb_cont_cal  = 1'b0;
        bus.rb_lock_dly  = 4'd8;
        bus.clr_lost     = '0;
        step(3);
        chk("rst_done", 32'(bus.dcc_done), 32'h0);
        chk("rst_lost", 32'(bus.lock_lost), 32'h0);
        chk("rst_reg", 32'(bus.dll_lock_reg), 32'h0);
        RST = 1'b0;
        step(9);
        chk("t1_done_edge9", 32'(bus.dcc_done), 32'h0);
        step(1);
        chk("t1_done_edge10", 32'(bus.dcc_done), 32'hF);

        // short lock pulse on ch0 never qualifies
        bus.dll_lock_mux[0] = 1'b0;
        step(3);
        bus.clr_lost[0] = 1'b1;
        step(1);
        bus.clr_lost[0] = 1'b0;
        bus.dll_lock_mux[0] = 1'b1;
        step(5);
        bus.dll_lock_mux[0] = 1'b0;
        step(8);
        chk("t2_pulse_done0", 32'(bus.dcc_done[0]), 32'h0);
        chk("t2_pulse_lost0", 32'(bus.lock_lost[0]), 32'h0);
        bus.dll_lock_mux[0] = 1'b1;
        step(9);
        chk("t2_relock_edge9", 32'(bus.dcc_done[0]), 32'h0);
        step(1);
        chk("t2_relock_edge10", 32'(bus.dcc_done[0]), 32'h1);

        // loss on ch1
        bus.dll_lock_mux[1] = 1'b0;
        step(2);
        chk("t3_done1_before", 32'(bus.dcc_done[1]), 32'h1);
        chk("t3_lost1_before", 32'(bus.lock_lost[1]), 32'h0);
        step(1);
        chk("t3_done1_after", 32'(bus.dcc_done[1]), 32'h0);
        chk("t3_lost1_after", 32'(bus.lock_lost[1]), 32'h1);
        bus.dll_lock_mux[1] = 1'b1;
        step(10);
        chk("t3_relock1", 32'(bus.dcc_done[1]), 32'h1);
        bus.clr_lost[1] = 1'b1;
        step(1);
        bus.clr_lost[1] = 1'b0;
        chk("t3_cleared1", 32'(bus.lock_lost[1]), 32'h0);
        bus.dll_lock_mux[1] = 1'b0;
        step(2);
        bus.clr_lost[1] = 1'b1;
        step(1);
        bus.clr_lost[1] = 1'b0;
        chk("t3_set_wins", 32'(bus.lock_lost[1]), 32'h1);
        chk("t3_done1_drop2", 32'(bus.dcc_done[1]), 32'h0);
        bus.dll_lock_mux[1] = 1'b1;
        step(10);

        // continuous-cal masking
        bus.rb_cont_cal = 1'b1;
        step(1);
        chk("t4_reg_masked", 32'(bus.dll_lock_reg), 32'h0);
        chk("t4_done_kept", 32'(bus.dcc_done), 32'hF);
        bus.rb_cont_cal = 1'b0;
        #1;
        chk("t4_reg_unmasked", 32'(bus.dll_lock_reg), 32'hF);

        // interval corner cases on ch3
        bus.dll_lock_mux[3] = 1'b0;
        step(3);
        bus.rb_lock_dly = 4'd0;
        bus.dll_lock_mux[3] = 1'b1;
        step(2);
        chk("t5_dly0_edge2", 32'(bus.dcc_done[3]), 32'h0);
        step(1);
        chk("t5_dly0_edge3", 32'(bus.dcc_done[3]), 32'h1);
        bus.dll_lock_mux[3] = 1'b0;
        step(3);
        bus.rb_lock_dly = 4'd15;
        bus.dll_lock_mux[3] = 1'b1;
        step(16);
        chk("t5_dly15_edge16", 32'(bus.dcc_done[3]), 32'h0);
        step(1);
        chk("t5_dly15_edge17", 32'(bus.dcc_done[3]), 32'h1);
        bus.dll_lock_mux[3] = 1'b0;
        step(3);
        bus.rb_lock_dly = 4'd8;
        bus.dll_lock_mux[3] = 1'b1;
        step(4);
        bus.rb_lock_dly = 4'd2;
        step(5);
        chk("t5_dlychg_edge9", 32'(bus.dcc_done[3]), 32'h0);
        step(1);
        chk("t5_dlychg_edge10", 32'(bus.dcc_done[3]), 32'h1);
        bus.rb_lock_dly = 4'd8;

`ifdef AIBCR3_LOCK_LOSS_CNT_EN
        bus.clr_lost[2] = 1'b1;
        step(1);
        bus.clr_lost[2] = 1'b0;
        chk("t6_cnt_init", 32'(bus.loss_cnt[2*LW +: LW]), 32'h0);
        bus.rb_lock_dly = 4'd0;
        for (int k = 0; k < 17; k++) begin
            bus.dll_lock_mux[2] = 1'b0;
            step(3);
            bus.dll_lock_mux[2] = 1'b1;
            step(3);
        end
        chk("t6_cnt_sat", 32'(bus.loss_cnt[2*LW +: LW]), 32'hF);
        bus.clr_lost[2] = 1'b1;
        step(1);
        bus.clr_lost[2] = 1'b0;
        chk("t6_cnt_clr", 32'(bus.loss_cnt[2*LW +: LW]), 32'h0);
        bus.dll_lock_mux[2] = 1'b0;
        step(2);
        bus.clr_lost[2] = 1'b1;
        step(1);
        bus.clr_lost[2] = 1'b0;
        chk("t6_cnt_clr_inc", 32'(bus.loss_cnt[2*LW +: LW]), 32'h1);
        bus.dll_lock_mux[2] = 1'b1;
        bus.rb_lock_dly = 4'd8;
        step(10);
`endif

        // reset in the middle of a WAIT count
        bus.dll_lock_mux[0] = 1'b0;
        step(3);
        bus.dll_lock_mux[0] = 1'b1;
        step(5);
        RST = 1'b1;
        step(1);
        chk("t6_rst_done", 32'(bus.dcc_done), 32'h0);
        chk("t6_rst_lost", 32'(bus.lock_lost), 32'h0);
        chk("t6_rst_reg", 32'(bus.dll_lock_reg), 32'h0);
`ifdef AIBCR3_LOCK_LOSS_CNT_EN
        chk("t6_rst_cnt", 32'(bus.loss_cnt), 32'h0);
`endif
        RST = 1'b0;
        step(9);
        chk("t6_after_rst_edge9", 32'(bus.dcc_done), 32'h0);
        step(1);
        chk("t6_after_rst_edge10", 32'(bus.dcc_done), 32'hF);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
